// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key-schedule engine.
//   AES_NR  : last round index for AES-128
//   word_t  : 32-bit key-schedule word
//   rkey_t  : 128-bit round key, [127:96] is the first word
//   RCON    : round constants for rounds 1..10
//   state_e : key-expansion FSM states
//   key_next: combines the current key with SubWord(RotWord(w3)) into the next round key
package aes_pkg;

  localparam int unsigned AES_NR = 10;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [0:0] {IDLE, EMIT} state_e;

  // sub_rot is SubWord(RotWord(w3)), produced by the S-box instances outside.
  function automatic rkey_t key_next(input rkey_t k, input word_t sub_rot, input logic [7:0] rc);
    word_t t, w4, w5, w6, w7;
    t  = sub_rot ^ {rc, 24'h0};
    w4 = k[127:96] ^ t;
    w5 = w4 ^ k[95:64];
    w6 = w5 ^ k[63:32];
    w7 = w6 ^ k[31:0];
    return {w4, w5, w6, w7};
  endfunction

endpackage

// File: rtl/S_box.sv
// AES forward S-box: combinational byte substitution.
//   data_i : input byte
//   data_o : substituted byte
module S_box (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign data_o = SBOX[data_i];

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
//   data_i : input word
//   data_o : byte-wise substituted word
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    S_box u_sbox (
      .data_i (data_i[8*b +: 8]),
      .data_o (data_o[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key-schedule engine. Latches a cipher key on start and streams round keys 0..10,
// one per valid/ready handshake, computing one full round key per cycle.
// Optional macro AES_KEY_STORE_EN adds an 11-entry round-key store with a registered read port.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_i     : begin expansion (accepted only when idle)
//   key_in_i    : cipher key, [127:96] = w0
//   busy_o      : run in progress
//   rk_valid_o  : round key available
//   rk_ready_i  : consumer accepts round key
//   rk_idx_o    : round index of rk_data_o
//   rk_data_o   : round key, [127:96] = first word
//   done_o      : one-cycle pulse after the final handshake
//   rd_idx_i    : store read index (store build only)
//   rd_data_o   : stored round key, one-cycle latency (0 without store)
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] key_in_i,
  output logic         busy_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [3:0]   rk_idx_o,
  output logic [127:0] rk_data_o,
  output logic         done_o,
  input  logic [3:0]   rd_idx_i,
  output logic [127:0] rd_data_o
);

  state_e      state_q, state_d;
  rkey_t       rk_data_q;
  logic [3:0]  rk_idx_q;
  logic        done_q;

  logic        accept_start;
  logic        handshake;
  logic        last_round;
  logic [7:0]  rcon;
  word_t       sub_rot;
  rkey_t       rk_next;

  assign accept_start = (state_q == IDLE) && start_i;
  assign handshake    = (state_q == EMIT) && rk_ready_i;
  assign last_round   = (rk_idx_q == 4'(NUM_ROUNDS));

  // Round constant for the key being produced; unused once the last round is out.
  always_comb begin
    rcon = 8'h00;
    if (!last_round) begin
      rcon = RCON[rk_idx_q + 4'd1];
    end
  end

  aes_sub_word u_sub_word (
    .data_i ({rk_data_q[23:0], rk_data_q[31:24]}),
    .data_o (sub_rot)
  );

  assign rk_next = key_next(rk_data_q, sub_rot, rcon);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = EMIT;
      EMIT: if (rk_ready_i && last_round) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o     = (state_q == EMIT);
    rk_valid_o = (state_q == EMIT);
    rk_idx_o   = rk_idx_q;
    rk_data_o  = rk_data_q;
    done_o     = done_q;
  end

  // Round-key datapath; a stalled handshake leaves key and index untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_data_q <= '0;
      rk_idx_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept_start) begin
        rk_data_q <= key_in_i;
        rk_idx_q  <= '0;
      end else if (handshake) begin
        if (last_round) begin
          done_q <= 1'b1;
        end else begin
          rk_data_q <= rk_next;
          rk_idx_q  <= rk_idx_q + 4'd1;
        end
      end
    end
  end

`ifdef AES_KEY_STORE_EN
  rkey_t store_q [11];
  rkey_t rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) begin
        store_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (handshake) begin
        store_q[rk_idx_q] <= rk_data_q;
      end
      rd_data_q <= (rd_idx_i <= 4'd10) ? store_q[rd_idx_i] : '0;
    end
  end

  assign rd_data_o = rd_data_q;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx_i;
  assign rd_data_o     = '0;
`endif

endmodule
